// File: rtl/projectile_flight_pkg.sv
// Shared definitions for the projectile flight block.
//   - ON/OFF single-bit constants
//   - state_t : flight controller states (exposed on the top's dbg_state port)
//   - pos_t   : signed 13-bit screen coordinate used by all position maths
//   - *_DEF   : default screen, ground, launch and target geometry
//   - sat_pos : saturates a signed coordinate into an unsigned 12-bit range
package projectile_flight_pkg;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLY      = 2'd1,
      ST_DONE     = 2'd2,
      ST_WAIT_REL = 2'd3
   } state_t;

   localparam int POS_W = 13;
   typedef logic signed [POS_W-1:0] pos_t;

   localparam int SCREEN_W_DEF = 1024;
   localparam int GROUND_Y_DEF = 460;
   localparam int START_X0_DEF = 100;
   localparam int START_X1_DEF = 924;
   localparam int START_Y_DEF  = 400;
   localparam int TGT_X0_DEF   = 880;
   localparam int TGT_X1_DEF   = 80;
   localparam int TGT_Y_DEF    = 400;
   localparam int TGT_W_DEF    = 48;
   localparam int TGT_H_DEF    = 60;

   // Negative values clamp to 0, values above hi clamp to hi.
   function automatic logic [11:0] sat_pos(input pos_t v, input logic [11:0] hi);
      logic [11:0] w_res;
      pos_t        w_hi;
      w_hi = pos_t'({1'b0, hi});
      if (v < 13'sd0) begin
         w_res = 12'd0;
      end else if (v > w_hi) begin
         w_res = hi;
      end else begin
         w_res = v[11:0];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/projectile_flight_proj_collide.sv
// proj_collide: purely combinational end-of-flight test for one position.
// Ports:
//   i_x, i_y   projectile position (signed, screen y grows downward)
//   i_tgt_x    left edge of the target box for the current thrower
//   o_hit      position lies inside the target box
//   o_end      flight is over: hit, on/below the ground line, or off screen
// The target box is half-open: [tgt_x, tgt_x+W) x [TGT_Y, TGT_Y+H).
module proj_collide
   import projectile_flight_pkg::*;
#(
   parameter int TGT_Y    = TGT_Y_DEF,
   parameter int TGT_W    = TGT_W_DEF,
   parameter int TGT_H    = TGT_H_DEF,
   parameter int GROUND_Y = GROUND_Y_DEF,
   parameter int SCREEN_W = SCREEN_W_DEF
) (
   input  pos_t i_x,
   input  pos_t i_y,
   input  pos_t i_tgt_x,
   output logic o_hit,
   output logic o_end
);

   localparam pos_t C_TGT_Y     = pos_t'(TGT_Y);
   localparam pos_t C_TGT_Y_END = pos_t'(TGT_Y + TGT_H);
   localparam pos_t C_TGT_W     = pos_t'(TGT_W);
   localparam pos_t C_GROUND_Y  = pos_t'(GROUND_Y);
   localparam pos_t C_SCREEN_W  = pos_t'(SCREEN_W);

   pos_t w_tgt_x_end;
   logic w_in_x;
   logic w_in_y;
   logic w_ground;
   logic w_exit;

   assign w_tgt_x_end = i_tgt_x + C_TGT_W;
   assign w_in_x      = (i_x >= i_tgt_x) && (i_x < w_tgt_x_end);
   assign w_in_y      = (i_y >= C_TGT_Y) && (i_y < C_TGT_Y_END);
   assign w_ground    = (i_y >= C_GROUND_Y);
   assign w_exit      = (i_x < 13'sd0) || (i_x >= C_SCREEN_W);

   assign o_hit = w_in_x & w_in_y;
   assign o_end = o_hit | w_ground | w_exit;

endmodule

// File: rtl/projectile_flight.sv
// projectile_flight: launches a projectile on the rising edge of throw_flag,
// steps integer ballistics once per frame_tick, and reports the outcome.
// Ports:
//   clk60MHz, rst_n   clock, asynchronous active-low reset
//   frame_tick        one-cycle pulse per video frame
//   throw_flag        launch request from the power meter
//   power[4:0]        launch speed, sampled on the throw_flag rising edge
//   current_player    0 throws rightwards, 1 throws leftwards; sampled with power
//   x_pos, y_pos      saturated projectile position for the draw block
//   proj_active       high while the projectile is in flight
//   end_throw         one-cycle pulse when the flight ends
//   hit               outcome of the last flight, valid from end_throw onward
//   dbg_state         current controller state
//
// Handshake with the power meter: a launch happens only on a 0->1 transition
// of throw_flag seen in IDLE; the block answers with exactly one end_throw
// pulse per flight and then waits for throw_flag to fall before re-arming, so
// a flag still high from the previous throw can never start a new flight.
module projectile_flight
   import projectile_flight_pkg::*;
#(
   parameter int START_X0   = START_X0_DEF,
   parameter int START_X1   = START_X1_DEF,
   parameter int START_Y    = START_Y_DEF,
   parameter int GROUND_Y   = GROUND_Y_DEF,
   parameter int SCREEN_W   = SCREEN_W_DEF,
   parameter int TGT_X0     = TGT_X0_DEF,
   parameter int TGT_X1     = TGT_X1_DEF,
   parameter int TGT_Y      = TGT_Y_DEF,
   parameter int TGT_W      = TGT_W_DEF,
   parameter int TGT_H      = TGT_H_DEF,
   parameter int GRAV_DIV   = 1,
   parameter int MAX_FRAMES = 255
) (
   input  logic        clk60MHz,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        throw_flag,
   input  logic [4:0]  power,
   input  logic        current_player,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        proj_active,
   output logic        end_throw,
   output logic        hit,
   output state_t      dbg_state
);

   localparam pos_t              C_START_X0   = pos_t'(START_X0);
   localparam pos_t              C_START_X1   = pos_t'(START_X1);
   localparam pos_t              C_START_Y    = pos_t'(START_Y);
   localparam pos_t              C_TGT_X0     = pos_t'(TGT_X0);
   localparam pos_t              C_TGT_X1     = pos_t'(TGT_X1);
   localparam logic [7:0]        C_GDIV_LAST  = 8'(GRAV_DIV - 1);
   localparam logic [8:0]        C_MAX_FRAMES = 9'(MAX_FRAMES);
   localparam logic signed [7:0] C_VY_MIN     = 8'sh80;
   localparam logic [11:0]       C_X_HI       = 12'(SCREEN_W - 1);
   localparam logic [11:0]       C_Y_HI       = 12'hFFF;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_flag_d;
   logic              r_player;
   logic              r_hit;
   pos_t              r_x;
   pos_t              r_y;
   logic [4:0]        r_vx;
   logic signed [7:0] r_vy;
   logic [7:0]        r_frames;
   logic [7:0]        r_gdiv;

   logic w_rise;
   logic w_launch;
   logic w_step;
   logic w_finish;
   logic w_timeout;
   logic w_col_hit;
   logic w_col_end;
   pos_t w_tgt_x;
   pos_t w_vx_ext;
   pos_t w_vy_ext;

   assign w_rise    = throw_flag & ~r_flag_d;
   assign w_tgt_x   = r_player ? C_TGT_X1 : C_TGT_X0;
   assign w_vx_ext  = pos_t'({8'd0, r_vx});
   assign w_vy_ext  = pos_t'({{5{r_vy[7]}}, r_vy});
   assign w_timeout = ({1'b0, r_frames} >= C_MAX_FRAMES);

   proj_collide #(
      .TGT_Y    (TGT_Y),
      .TGT_W    (TGT_W),
      .TGT_H    (TGT_H),
      .GROUND_Y (GROUND_Y),
      .SCREEN_W (SCREEN_W)
   ) u_collide (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_tgt_x (w_tgt_x),
      .o_hit   (w_col_hit),
      .o_end   (w_col_end)
   );

   // End checks only run on non-tick cycles so they always see the position
   // produced by the previous tick; a flight therefore ends one cycle after
   // the tick that caused it.
   assign w_launch = (r_state == ST_IDLE) && w_rise;
   assign w_step   = (r_state == ST_FLY) && frame_tick;
   assign w_finish = (r_state == ST_FLY) && !frame_tick && (w_col_end || w_timeout);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:     if (w_launch) w_state_nxt = ST_FLY;
         ST_FLY:      if (w_finish) w_state_nxt = ST_DONE;
         ST_DONE:     w_state_nxt = ST_WAIT_REL;
         ST_WAIT_REL: if (!throw_flag) w_state_nxt = ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
   end

   // Resetting the flag copy high means a throw_flag already asserted when
   // reset is released does not look like a fresh rising edge.
   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_flag_d <= ON;
      end else begin
         r_state  <= w_state_nxt;
         r_flag_d <= throw_flag;
      end
   end

   always_ff @(posedge clk60MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_vx     <= '0;
         r_vy     <= '0;
         r_frames <= '0;
         r_gdiv   <= '0;
         r_player <= OFF;
         r_hit    <= OFF;
      end else if (w_launch) begin
         r_x      <= current_player ? C_START_X1 : C_START_X0;
         r_y      <= C_START_Y;
         r_vx     <= power;
         r_vy     <= $signed({3'b000, power});
         r_frames <= '0;
         r_gdiv   <= '0;
         r_player <= current_player;
         r_hit    <= OFF;
      end else if (w_step) begin
         r_x <= r_player ? (r_x - w_vx_ext) : (r_x + w_vx_ext);
         r_y <= r_y - w_vy_ext;
         if (r_gdiv == C_GDIV_LAST) begin
            r_gdiv <= '0;
            if (r_vy != C_VY_MIN) begin
               r_vy <= r_vy - 8'sd1;
            end
         end else begin
            r_gdiv <= r_gdiv + 8'd1;
         end
         if (r_frames != 8'hFF) begin
            r_frames <= r_frames + 8'd1;
         end
      end else if (w_finish) begin
         // Target test takes priority over ground/exit in the same evaluation.
         r_hit <= w_col_hit;
      end
   end

   assign x_pos       = sat_pos(r_x, C_X_HI);
   assign y_pos       = sat_pos(r_y, C_Y_HI);
   assign proj_active = (r_state == ST_FLY)  ? ON : OFF;
   assign end_throw   = (r_state == ST_DONE) ? ON : OFF;
   assign hit         = r_hit;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_projectile_flight.sv
// Self-checking bench for projectile_flight. Four instances share the clock,
// reset, frame_tick, power and current_player; each has its own throw_flag:
//   0: default parameters
//   1: TGT_X0=280, TGT_H=80  (target entered on the same tick as the ground)
//   2: GRAV_DIV=8            (fast shot leaving the screen)
//   3: MAX_FRAMES=5          (timeout)
module tb_projectile_flight;
   import projectile_flight_pkg::*;

   localparam int N_INST = 4;

   logic        clk60MHz;
   logic        rst_n;
   logic        frame_tick;
   logic [4:0]  power;
   logic        current_player;
   logic        throw_flag_a  [N_INST];
   logic [11:0] x_pos_a       [N_INST];
   logic [11:0] y_pos_a       [N_INST];
   logic        proj_active_a [N_INST];
   logic        end_throw_a   [N_INST];
   logic        hit_a         [N_INST];
   state_t      state_a       [N_INST];

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] pos_q [$];
   logic [1:0]  res_q [$];

   // Reference model state (plain integers)
   int m_x, m_y, m_vx, m_vy, m_div, m_frames, m_player;

   // ---------------- clock / reset ----------------
   initial begin
      clk60MHz = 1'b0;
      forever #8 clk60MHz = ~clk60MHz;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUT instances ----------------
   projectile_flight u_dut0 (
      .clk60MHz(clk60MHz), .rst_n(rst_n), .frame_tick(frame_tick),
      .throw_flag(throw_flag_a[0]), .power(power), .current_player(current_player),
      .x_pos(x_pos_a[0]), .y_pos(y_pos_a[0]), .proj_active(proj_active_a[0]),
      .end_throw(end_throw_a[0]), .hit(hit_a[0]), .dbg_state(state_a[0]));

   projectile_flight #(.TGT_X0(280), .TGT_H(80)) u_dut1 (
      .clk60MHz(clk60MHz), .rst_n(rst_n), .frame_tick(frame_tick),
      .throw_flag(throw_flag_a[1]), .power(power), .current_player(current_player),
      .x_pos(x_pos_a[1]), .y_pos(y_pos_a[1]), .proj_active(proj_active_a[1]),
      .end_throw(end_throw_a[1]), .hit(hit_a[1]), .dbg_state(state_a[1]));

   projectile_flight #(.GRAV_DIV(8)) u_dut2 (
      .clk60MHz(clk60MHz), .rst_n(rst_n), .frame_tick(frame_tick),
      .throw_flag(throw_flag_a[2]), .power(power), .current_player(current_player),
      .x_pos(x_pos_a[2]), .y_pos(y_pos_a[2]), .proj_active(proj_active_a[2]),
      .end_throw(end_throw_a[2]), .hit(hit_a[2]), .dbg_state(state_a[2]));

   projectile_flight #(.MAX_FRAMES(5)) u_dut3 (
      .clk60MHz(clk60MHz), .rst_n(rst_n), .frame_tick(frame_tick),
      .throw_flag(throw_flag_a[3]), .power(power), .current_player(current_player),
      .x_pos(x_pos_a[3]), .y_pos(y_pos_a[3]), .proj_active(proj_active_a[3]),
      .end_throw(end_throw_a[3]), .hit(hit_a[3]), .dbg_state(state_a[3]));

   // ---------------- per-instance parameters ----------------
   function automatic int inst_tgt_x0(input int i);
      return (i == 1) ? 280 : 880;
   endfunction
   function automatic int inst_tgt_h(input int i);
      return (i == 1) ? 80 : 60;
   endfunction
   function automatic int inst_grav(input int i);
      return (i == 2) ? 8 : 1;
   endfunction
   function automatic int inst_maxf(input int i);
      return (i == 3) ? 5 : 255;
   endfunction
   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at time %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_launch(input int player, input int pwr);
      m_player = player;
      m_x      = (player != 0) ? 924 : 100;
      m_y      = 400;
      m_vx     = pwr;
      m_vy     = pwr;
      m_div    = 0;
      m_frames = 0;
   endtask

   task automatic model_tick(input int inst, output bit e, output bit h);
      int tx;
      m_x = (m_player != 0) ? (m_x - m_vx) : (m_x + m_vx);
      m_y = m_y - m_vy;
      m_div++;
      if (m_div >= inst_grav(inst)) begin
         m_div = 0;
         if (m_vy > -128) m_vy--;
      end
      m_frames++;
      tx = (m_player != 0) ? 80 : inst_tgt_x0(inst);
      h = (m_x >= tx) && (m_x < tx + 48) && (m_y >= 400) && (m_y < 400 + inst_tgt_h(inst));
      e = h || (m_y >= 460) || (m_x < 0) || (m_x >= 1024) || (m_frames >= inst_maxf(inst));
   endtask

   // ---------------- driver tasks ----------------
   task automatic launch(input int inst, input int player, input int pwr);
      @(negedge clk60MHz);
      power          = 5'(pwr);
      current_player = 1'(player);
      throw_flag_a[inst] = 1'b1;
      model_launch(player, pwr);
      @(negedge clk60MHz);
      check("launch_active", 32'(proj_active_a[inst]), 32'd1);
      check("launch_x", 32'(x_pos_a[inst]), 32'(m_x));
      check("launch_y", 32'(y_pos_a[inst]), 32'(m_y));
      check("launch_hit", 32'(hit_a[inst]), 32'd0);
      // Changing power after the edge must not affect the flight.
      power = ~power;
   endtask

   task automatic fly(input int inst, input int max_ticks, output bit ended, output int n_ticks);
      bit          e;
      bit          h;
      logic [23:0] exp_pos;
      logic [1:0]  exp_res;
      ended   = 1'b0;
      n_ticks = 0;
      while (!ended && n_ticks < max_ticks) begin
         model_tick(inst, e, h);
         pos_q.push_back({12'(clampi(m_x, 0, 1023)), 12'(clampi(m_y, 0, 4095))});
         res_q.push_back({e, h});
         n_ticks++;
         frame_tick = 1'b1;
         @(negedge clk60MHz);
         frame_tick = 1'b0;
         exp_pos = pos_q.pop_front();
         check("tick_x", 32'(x_pos_a[inst]), 32'(exp_pos[23:12]));
         check("tick_y", 32'(y_pos_a[inst]), 32'(exp_pos[11:0]));
         @(negedge clk60MHz);
         exp_res = res_q.pop_front();
         check("end_pulse", 32'(end_throw_a[inst]), 32'(exp_res[1]));
         if (exp_res[1]) begin
            check("end_hit", 32'(hit_a[inst]), 32'(exp_res[0]));
            check("end_active", 32'(proj_active_a[inst]), 32'd0);
            @(negedge clk60MHz);
            check("end_width", 32'(end_throw_a[inst]), 32'd0);
            check("end_state", 32'(state_a[inst]), 32'(ST_WAIT_REL));
            ended = 1'b1;
         end
      end
   endtask

   task automatic release_flag(input int inst);
      @(negedge clk60MHz);
      throw_flag_a[inst] = 1'b0;
      @(negedge clk60MHz);
      @(negedge clk60MHz);
      check("release_idle", 32'(state_a[inst]), 32'(ST_IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ended;
      int nt;
      int pwr;
      int ply;

      rst_n          = 1'b0;
      frame_tick     = 1'b0;
      power          = 5'd0;
      current_player = 1'b0;
      for (int i = 0; i < N_INST; i++) throw_flag_a[i] = 1'b0;
      repeat (3) @(negedge clk60MHz);
      check("rst_x", 32'(x_pos_a[0]), 32'd0);
      check("rst_y", 32'(y_pos_a[0]), 32'd0);
      check("rst_active", 32'(proj_active_a[0]), 32'd0);
      check("rst_end", 32'(end_throw_a[0]), 32'd0);
      check("rst_hit", 32'(hit_a[0]), 32'd0);
      for (int i = 0; i < N_INST; i++) check("rst_state", 32'(state_a[i]), 32'(ST_IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk60MHz);

      // Reset in the middle of a flight, with throw_flag still high on release.
      launch(0, 0, 10);
      fly(0, 3, ended, nt);
      check("midflight_ticks", 32'(nt), 32'd3);
      rst_n = 1'b0;
      #1;
      check("abort_x", 32'(x_pos_a[0]), 32'd0);
      check("abort_y", 32'(y_pos_a[0]), 32'd0);
      check("abort_active", 32'(proj_active_a[0]), 32'd0);
      check("abort_state", 32'(state_a[0]), 32'(ST_IDLE));
      repeat (3) @(negedge clk60MHz);
      check("abort_no_end", 32'(end_throw_a[0]), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk60MHz);
      check("stale_flag_idle", 32'(state_a[0]), 32'(ST_IDLE));
      check("stale_flag_inactive", 32'(proj_active_a[0]), 32'd0);
      release_flag(0);

      // Vertical drop: power 0 lands on tick 12 at y = 466.
      launch(0, 0, 0);
      fly(0, 40, ended, nt);
      check("drop_ended", 32'(ended), 32'd1);
      check("drop_ticks", 32'(nt), 32'd12);
      check("drop_x", 32'(x_pos_a[0]), 32'd100);
      check("drop_y", 32'(y_pos_a[0]), 32'd466);

      // Flag held high after end_throw: no relaunch, frame ticks ignored.
      for (int c = 0; c < 50; c++) begin
         @(negedge clk60MHz);
         frame_tick = (c % 10 == 5) ? 1'b1 : 1'b0;
      end
      @(negedge clk60MHz);
      frame_tick = 1'b0;
      check("hold_state", 32'(state_a[0]), 32'(ST_WAIT_REL));
      check("hold_active", 32'(proj_active_a[0]), 32'd0);
      check("hold_y", 32'(y_pos_a[0]), 32'd466);
      release_flag(0);

      // Player 1, power 10: freshly sampled power, leftward flight.
      launch(0, 1, 10);
      fly(0, 60, ended, nt);
      check("p1_ended", 32'(ended), 32'd1);
      check("p1_ticks", 32'(nt), 32'd26);
      check("p1_x", 32'(x_pos_a[0]), 32'd664);
      release_flag(0);

      // Target entered on the same tick that reaches the ground: hit wins.
      launch(1, 0, 8);
      fly(1, 60, ended, nt);
      check("prio_ended", 32'(ended), 32'd1);
      check("prio_ticks", 32'(nt), 32'd23);
      check("prio_hit", 32'(hit_a[1]), 32'd1);
      release_flag(1);

      // Full power with slow gravity: exits right, x_pos clamps to 1023.
      launch(2, 0, 31);
      fly(2, 80, ended, nt);
      check("exit_ended", 32'(ended), 32'd1);
      check("exit_ticks", 32'(nt), 32'd30);
      check("exit_x_clamp", 32'(x_pos_a[2]), 32'd1023);
      check("exit_hit", 32'(hit_a[2]), 32'd0);
      release_flag(2);

      // Timeout after 5 frames.
      launch(3, 0, 10);
      fly(3, 20, ended, nt);
      check("timeout_ended", 32'(ended), 32'd1);
      check("timeout_ticks", 32'(nt), 32'd5);
      release_flag(3);

      // Random flights on the default instance.
      for (int k = 0; k < 6; k++) begin
         pwr = int'($urandom_range(31, 0));
         ply = int'($urandom_range(1, 0));
         launch(0, ply, pwr);
         fly(0, 300, ended, nt);
         check("rand_ended", 32'(ended), 32'd1);
         release_flag(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
